unary_shift_multiplier: RTL and testbench
=========================================

UNARY_SHIFT_MULTIPLIER -- requirements
Module: unary_shift_multiplier

Interface
REQ-001 SHALL have parameter BIN_BITS, default 4: binary width of each operand count; product width is 2*BIN_BITS.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_a  input  1  operand A as a unary stream: A consecutive cycles high, then low.
REQ-005 SHALL have port in_b  input  1  operand B as a unary stream, starting on the same cycle as in_a.
REQ-006 SHALL have port out  output  1  product as a unary stream: exactly A*B high cycles per operation.
REQ-007 SHALL have port zero  output  1  high when no output pulses are pending.

Function
REQ-008 SHALL use states IDLE, LOAD, MULT and EMIT; all outputs are registered.
REQ-009 In IDLE, a rising edge sampling in_a|in_b = 1 SHALL count that sample and move to LOAD.
- Counting rule: cnt_a += in_a, cnt_b += in_b.
REQ-010 In LOAD, each edge with in_a|in_b = 1 SHALL count as in REQ-009; the first edge with both low SHALL move to MULT.
- Streams of different length are legal.
- A zero-length stream leaves its count at 0.
REQ-011 MULT SHALL compute prod = cnt_a*cnt_b by shift-and-add over exactly BIN_BITS cycles, one multiplier bit per cycle, LSB first.
REQ-012 After MULT, if prod = 0 the block SHALL return to IDLE; otherwise it SHALL enter EMIT.
REQ-013 In EMIT, out SHALL be 1 for exactly prod consecutive cycles (prod decremented per pulse), then the block SHALL return to IDLE with out = 0.
REQ-014 On return to IDLE, cnt_a, cnt_b and prod SHALL be cleared.
REQ-015 in_a and in_b SHALL be ignored in MULT and EMIT.
REQ-016 out SHALL never be 1 outside EMIT.
REQ-017 Worst-case latency from the last input sample to the last out pulse SHALL be at most BIN_BITS + (2^BIN_BITS-1)^2 + 2 cycles (231 for the default).
REQ-018 zero SHALL be 1 in IDLE and LOAD.
- In MULT, zero SHALL be 0.
- In EMIT, zero SHALL be 1 only on the cycle after the final pulse.
REQ-019 In IDLE, a cycle with in_a = 0 and in_b = 0 SHALL keep the block in IDLE with no side effects.

Reset
REQ-020 reset_n low SHALL immediately force state IDLE, clear cnt_a, cnt_b and prod, and set out = 0 and zero = 1, independent of clk.
REQ-021 Reset asserted mid-LOAD, mid-MULT or mid-EMIT SHALL abort the operation with no further out pulses.
REQ-022 After reset_n deasserts, the first in_a|in_b = 1 sample SHALL start a fresh operation.

Configuration
REQ-023 With macro UNARY_MULT_SATURATE_EN defined, cnt_a and cnt_b SHALL saturate at 2^BIN_BITS-1 when a stream is longer.
REQ-024 Without UNARY_MULT_SATURATE_EN, cnt_a and cnt_b SHALL wrap modulo 2^BIN_BITS.

Verification
REQ-025 Reset, then A=3, B=2 (in_a 3 cycles, in_b 2 cycles, simultaneous start) -> exactly 6 out pulses within 260 cycles; zero = 1 afterwards.
REQ-026 A=4, B=15 -> 60 pulses; A=10, B=9 -> 90 pulses, contiguous.
REQ-027 A=3, B=0, and A=0, B=5 -> 0 out pulses; block back in IDLE BIN_BITS+1 cycles after the inputs end.
REQ-028 A=15, B=15 -> 225 pulses, last pulse no more than 231 cycles after the last input high.
REQ-029 A=5, B=4 with reset_n pulsed low during EMIT -> out = 0 immediately; next A=2, B=3 -> 6 pulses.
REQ-030 A stream of 17 ones with B=1 -> 15 pulses with UNARY_MULT_SATURATE_EN defined; 1 pulse without it.

Source files
------------

// File: rtl/unary_shift_multiplier.sv
// Unary-stream multiplier: counts two unary operand streams, multiplies the
// counts by shift-and-add, then emits the product as a unary pulse train.
// Optional macro UNARY_MULT_SATURATE_EN: operand counters saturate instead of wrap.
module unary_shift_multiplier #(
    parameter int unsigned BIN_BITS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_a,
    input  logic in_b,
    output logic out,
    output logic zero
);

    localparam int unsigned PROD_BITS = 2 * BIN_BITS;
    localparam int unsigned STEP_BITS = $clog2(BIN_BITS) + 1;
    localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(BIN_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MULT, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [BIN_BITS-1:0]    cnt_a_q, cnt_a_d;
    logic [BIN_BITS-1:0]    cnt_b_q, cnt_b_d;
    logic [PROD_BITS-1:0]   mcand_q, mcand_d;
    logic [PROD_BITS-1:0]   prod_q, prod_d;
    logic [STEP_BITS-1:0]   step_q, step_d;
    logic                   out_q, out_d;
    logic                   zero_q, zero_d;
    logic                   any_in;
    logic [PROD_BITS-1:0]   prod_sum;

    function automatic logic [BIN_BITS-1:0] count_up(input logic [BIN_BITS-1:0] c,
                                                     input logic en);
`ifdef UNARY_MULT_SATURATE_EN
        if (en && (c != {BIN_BITS{1'b1}})) return c + 1'b1;
        return c;
`else
        return c + BIN_BITS'(en);
`endif
    endfunction

    assign any_in   = in_a | in_b;
    // cnt_b doubles as the multiplier shift register, consumed LSB first
    assign prod_sum = prod_q + (cnt_b_q[0] ? mcand_q : '0);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_in) state_d = LOAD;
            LOAD:    if (!any_in) state_d = MULT;
            MULT:    if (step_q == LAST_STEP) state_d = (prod_sum == '0) ? IDLE : EMIT;
            EMIT:    if (prod_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: counting, shift-and-add, pulse countdown
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (any_in) begin
                    cnt_a_d = count_up(cnt_a_q, in_a);
                    cnt_b_d = count_up(cnt_b_q, in_b);
                end else if (state_q == LOAD) begin
                    mcand_d = {{BIN_BITS{1'b0}}, cnt_a_q};
                    prod_d  = '0;
                    step_d  = '0;
                end
            end
            MULT: begin
                prod_d  = prod_sum;
                mcand_d = mcand_q << 1;
                cnt_b_d = cnt_b_q >> 1;
                step_d  = step_q + 1'b1;
            end
            EMIT: begin
                if (prod_q != '0) prod_d = prod_q - 1'b1;
            end
            default: ;
        endcase
        // Everything is wiped whenever the block lands in IDLE
        if (state_d == IDLE) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
            mcand_d = '0;
            prod_d  = '0;
            step_d  = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            step_q  <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            step_q  <= step_d;
        end
    end

    // Output decode from next state: pulse while pulses remain, zero once none pending
    always_comb begin
        out_d  = (state_d == EMIT) && (prod_d != '0);
        zero_d = !((state_d == MULT) || ((state_d == EMIT) && (prod_d != '0)));
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
        end
    end

    assign out  = out_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_unary_shift_multiplier.sv
// Scoreboard bench for unary_shift_multiplier: each operation pushes its
// expected pulse count and deadline; a monitor closes an operation on every
// rising edge of zero and compares pulses, contiguity and timing.
module tb_unary_shift_multiplier;

    localparam int unsigned BIN_BITS = 4;
    localparam int          PERIOD   = 10;
    // last pulse must start within BIN_BITS + 15*15 + 2 cycles of the last input edge
    localparam int          WORST    = BIN_BITS + 225 + 2;

    logic clk = 1'b0;
    logic reset_n;
    logic in_a;
    logic in_b;
    logic out;
    logic zero;

    typedef struct {
        int  pulses;
        time deadline;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    unary_shift_multiplier #(.BIN_BITS(BIN_BITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_a    (in_a),
        .in_b    (in_b),
        .out     (out),
        .zero    (zero)
    );

    always #(PERIOD / 2) clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one operation; inputs change on negedges, sampled on the next posedge
    task automatic run_op(input int a, input int b, input int exp_pulses, input bit push);
        int   n;
        time  t_last;
        exp_t e;
        n = (a > b) ? a : b;
        @(negedge clk);
        t_last = $time + time'((n - 1) * PERIOD);
        if (push) begin
            e.pulses   = exp_pulses;
            e.deadline = (exp_pulses == 0) ? t_last + time'((BIN_BITS + 2) * PERIOD)
                                           : t_last + time'((WORST + 1) * PERIOD);
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            in_a = (i < a);
            in_b = (i < b);
        end
        @(negedge clk);
        in_a = 1'b0;
        in_b = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: %0d operations still pending, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: accumulate pulses, close an operation when zero rises
    initial begin : monitor
        int   pulses;
        int   bursts;
        logic prev_out;
        logic prev_zero;
        time  last_t;
        time  ref_t;
        exp_t e;
        pulses = 0; bursts = 0; prev_out = 1'b0; prev_zero = 1'b1; last_t = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pulses = 0; bursts = 0; prev_out = 1'b0; prev_zero = 1'b1;
            end else begin
                if (out) begin
                    pulses++;
                    last_t = $time;
                    if (!prev_out) bursts++;
                end
                if (zero && !prev_zero) begin
                    if (sb.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_op: %0d pulses, expected no operation", pulses);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_count", pulses, e.pulses);
                        check("burst_count", bursts, (e.pulses != 0) ? 1 : 0);
                        ref_t = (e.pulses != 0) ? last_t : $time;
                        check("in_time", (ref_t <= e.deadline) ? 1 : 0, 1);
                    end
                    pulses = 0;
                    bursts = 0;
                end
                prev_out  = out;
                prev_zero = zero;
            end
        end
    end

    initial begin : stimulus
        int k;
        reset_n = 1'b0;
        in_a    = 1'b0;
        in_b    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_zero", zero, 1);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_zero", zero, 1);

        run_op(3, 2, 6, 1'b1);   wait_drain("a3b2");
        check("after_zero", zero, 1);
        run_op(4, 15, 60, 1'b1); wait_drain("a4b15");
        run_op(10, 9, 90, 1'b1); wait_drain("a10b9");
        run_op(3, 0, 0, 1'b1);   wait_drain("a3b0");
        run_op(0, 5, 0, 1'b1);   wait_drain("a0b5");
        run_op(15, 15, 225, 1'b1); wait_drain("a15b15");

        // Abort during EMIT: operation is not scored, reset must silence out at once
        run_op(5, 4, 20, 1'b0);
        for (k = 0; k < 300 && !out; k++) @(negedge clk);
        check("abort_reached_emit", out, 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_out", out, 0);
        check("abort_zero", zero, 1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(2, 3, 6, 1'b1);   wait_drain("a2b3");

`ifdef UNARY_MULT_SATURATE_EN
        run_op(17, 1, 15, 1'b1);
`else
        run_op(17, 1, 1, 1'b1);
`endif
        wait_drain("a17b1");
        check("final_zero", zero, 1);
        check("final_out", out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
